// File: rtl/red_carry_resolve_pkg.sv
// Shared parameters for the BN254 redundant-polynomial carry resolver.
//   - limb/carry width defaults (LIMB_W = LEN_12M_TILDE/ADD_DIV, N_LIMB = ADD_DIV)
//   - carry widths of the redundant_poly_L1/L2/L3 representations
//   - result typedef at the default width
//   - FSM state encoding
// No ports; imported by red_carry_resolve.
package red_carry_resolve_pkg;

   localparam int LEN_12M_TILDE = 404;
   localparam int ADD_DIV       = 4;

   // Carry widths of the existing redundant forms L1/L2/L3.
   localparam int L1_CARRY = 1;
   localparam int L2_CARRY = 2;
   localparam int L3_CARRY = 8;

   localparam int DEF_LIMB_W  = LEN_12M_TILDE / ADD_DIV;
   localparam int DEF_N_LIMB  = ADD_DIV;
   localparam int DEF_CARRY_W = L3_CARRY;
   localparam int DEF_OUT_W   = DEF_N_LIMB*DEF_LIMB_W + DEF_CARRY_W + 1;

   typedef logic [DEF_OUT_W-1:0] result_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PROP = 2'd1,
      SUB  = 2'd2,
      DONE = 2'd3
   } rcr_state_e;

endpackage

// File: rtl/red_limb_add.sv
// red_limb_add: combinational limb adder for the carry resolver.
// Ports:
//   val_i   [LIMB_W-1:0]  limb value
//   carry_i [CARRY_W-1:0] carry field of the limb below (0 for limb 0)
//   p_i     [CARRY_W:0]   propagate from the previous limb
//   sum_o   [LIMB_W-1:0]  low LIMB_W bits of the sum
//   cout_o  [CARRY_W:0]   sum >> LIMB_W
module red_limb_add #(
   parameter int LIMB_W  = 8,
   parameter int CARRY_W = 2
) (
   input  logic [LIMB_W-1:0]  val_i,
   input  logic [CARRY_W-1:0] carry_i,
   input  logic [CARRY_W:0]   p_i,
   output logic [LIMB_W-1:0]  sum_o,
   output logic [CARRY_W:0]   cout_o
);

   // val + carry + p < 2^LIMB_W + 2^(CARRY_W+2), which always fits in
   // LIMB_W+CARRY_W+1 bits, so the carry-out is exactly CARRY_W+1 bits.
   localparam int SW = LIMB_W + CARRY_W + 1;

   logic [SW-1:0] s;

   assign s      = SW'(val_i) + SW'(carry_i) + SW'(p_i);
   assign sum_o  = s[LIMB_W-1:0];
   assign cout_o = s[SW-1:LIMB_W];

endmodule

// File: rtl/red_carry_resolve.sv
// red_carry_resolve: converts a redundant polynomial (per-limb value + carry)
// into its canonical integer, one limb per cycle, with an optional single
// conditional subtraction of SUB_CONST.
// Ports:
//   clk, rst                synchronous active-high reset
//   in_valid / in_ready     input handshake; in_ready only while IDLE
//   in_poly                 N_LIMB limbs of {carry[CARRY_W], val[LIMB_W]}, limb 0 in LSBs
//   out_valid / out_ready   output handshake; out_valid only while DONE
//   out_uint [OUT_W-1:0]    exact value, OUT_W = N_LIMB*LIMB_W + CARRY_W + 1
module red_carry_resolve
   import red_carry_resolve_pkg::*;
#(
   parameter int LIMB_W  = DEF_LIMB_W,
   parameter int N_LIMB  = DEF_N_LIMB,
   parameter int CARRY_W = DEF_CARRY_W,
   parameter int RED_EN  = 0,
   parameter logic [N_LIMB*LIMB_W+CARRY_W:0] SUB_CONST = '0
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [N_LIMB*(CARRY_W+LIMB_W)-1:0]    in_poly,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [N_LIMB*LIMB_W+CARRY_W:0]        out_uint
);

   localparam int OUT_W = N_LIMB*LIMB_W + CARRY_W + 1;
   localparam int LW    = CARRY_W + LIMB_W;
   localparam int CNT_W = $clog2(N_LIMB);

   rcr_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CARRY_W:0]       p_q, p_d;
   logic [OUT_W-1:0]       res_q, res_d;
   logic [N_LIMB*LW-1:0]   poly_q, poly_d;

   logic [LIMB_W-1:0]      val_a [N_LIMB];
   logic [CARRY_W-1:0]     car_a [N_LIMB];
   logic [LIMB_W-1:0]      cur_val;
   logic [CARRY_W-1:0]     prev_car;
   logic [LIMB_W-1:0]      sum;
   logic [CARRY_W:0]       cout;
   logic [CARRY_W:0]       top_f;
   logic                   last;

   for (genvar j = 0; j < N_LIMB; j++) begin : g_limb
      assign val_a[j] = poly_q[j*LW +: LIMB_W];
      assign car_a[j] = poly_q[j*LW+LIMB_W +: CARRY_W];
   end

   // Limb cnt adds its own value plus the carry field of the limb below,
   // since that carry is weighted 2^LIMB_W relative to its own limb.
   assign cur_val  = val_a[cnt_q];
   assign prev_car = (cnt_q == '0) ? '0 : car_a[cnt_q - 1'b1];
   assign last     = (cnt_q == CNT_W'(N_LIMB-1));

   red_limb_add #(
      .LIMB_W  (LIMB_W),
      .CARRY_W (CARRY_W)
   ) u_add (
      .val_i   (cur_val),
      .carry_i (prev_car),
      .p_i     (p_q),
      .sum_o   (sum),
      .cout_o  (cout)
   );

   // Top field: carry of the highest limb plus the final propagate.
   assign top_f = (CARRY_W+1)'(car_a[N_LIMB-1]) + cout;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      res_d   = res_q;
      poly_d  = poly_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               poly_d  = in_poly;
               cnt_d   = '0;
               p_d     = '0;
               state_d = PROP;
            end
         end
         PROP: begin
            for (int j = 0; j < N_LIMB; j++) begin
               if (cnt_q == CNT_W'(j)) res_d[j*LIMB_W +: LIMB_W] = sum;
            end
            p_d   = cout;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               res_d[N_LIMB*LIMB_W +: CARRY_W+1] = top_f;
               cnt_d   = '0;
               state_d = (RED_EN != 0) ? SUB : DONE;
            end
         end
         SUB: begin
            // One subtraction only: the result is reduced, not fully modded.
            if (res_q >= SUB_CONST) res_d = res_q - SUB_CONST;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         res_q   <= '0;
         poly_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         res_q   <= res_d;
         poly_q  <= poly_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_uint  = res_q;

endmodule

// File: tb/tb_red_carry_resolve.sv
module tb_red_carry_resolve;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Small instances (LIMB_W=8, N_LIMB=4, CARRY_W=2) share their inputs.
   logic        iv, or_;
   logic [39:0] ip;
   logic        a_ir, a_ov, r_ir, r_ov;
   logic [34:0] a_ou, r_ou;

   // Default-parameter instance.
   logic         d_iv, d_or;
   logic [435:0] d_ip;
   logic         d_ir, d_ov;
   logic [412:0] d_ou;

   red_carry_resolve #(.LIMB_W(8), .N_LIMB(4), .CARRY_W(2), .RED_EN(0)) u_a (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(a_ir), .in_poly(ip),
      .out_valid(a_ov), .out_ready(or_), .out_uint(a_ou));

   red_carry_resolve #(.LIMB_W(8), .N_LIMB(4), .CARRY_W(2), .RED_EN(1),
                       .SUB_CONST(35'h100)) u_r (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(r_ir), .in_poly(ip),
      .out_valid(r_ov), .out_ready(or_), .out_uint(r_ou));

   red_carry_resolve u_d (
      .clk(clk), .rst(rst), .in_valid(d_iv), .in_ready(d_ir), .in_poly(d_ip),
      .out_valid(d_ov), .out_ready(d_or), .out_uint(d_ou));

   int errors = 0;
   int checks = 0;
   int npop   = 0;
   bit gen_done = 1'b0;
   logic [412:0] exp_q[$];

   task automatic chk(input string nm, input logic [412:0] act, input logic [412:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference: value = sum_j (val[j] + carry[j]*2^101) * 2^(101*j)
   function automatic logic [412:0] ref_val(input logic [435:0] pw);
      logic [412:0] acc, t;
      acc = '0;
      for (int j = 0; j < 4; j++) begin
         t   = 413'(pw[j*109 +: 101]) + (413'(pw[j*109+101 +: 8]) << 101);
         acc = acc + (t << (j*101));
      end
      return acc;
   endfunction

   // Scoreboard pop for the default instance.
   always @(negedge clk) begin
      if (!rst && d_ov && d_or) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_out", 413'(1), 413'(0));
         end else begin
            chk("rand_word", d_ou, exp_q.pop_front());
            npop++;
         end
      end
   end

   typedef struct {
      logic [39:0] poly;
      logic [34:0] ea;   // RED_EN=0
      logic [34:0] er;   // RED_EN=1, SUB_CONST=0x100
   } vec_t;

   vec_t tbl[8];

   // One word through u_a and u_r; checks latency and value, then releases both.
   task automatic run_vec(input int i, input vec_t v);
      int la, lr;
      la = 0; lr = 0;
      ip = v.poly; iv = 1'b1;
      @(posedge clk); #1;
      iv = 1'b0; ip = 40'hA5A5A5A5A5;
      for (int e = 1; e <= 10; e++) begin
         @(posedge clk); #1;
         if (e == 1) chk($sformatf("vec%0d_busy_ready", i), 413'(a_ir), 413'(0));
         if (a_ov && la == 0) la = e;
         if (r_ov && lr == 0) lr = e;
         if (la != 0 && lr != 0) break;
      end
      chk($sformatf("vec%0d_lat_a", i), 413'(la), 413'(4));
      chk($sformatf("vec%0d_lat_r", i), 413'(lr), 413'(5));
      chk($sformatf("vec%0d_val_a", i), 413'(a_ou), 413'(v.ea));
      chk($sformatf("vec%0d_val_r", i), 413'(r_ou), 413'(v.er));
      or_ = 1'b1;
      @(posedge clk); #1;
      or_ = 1'b0;
   endtask

   initial begin
      logic [435:0] rp;
      bit seen;

      tbl[0] = '{{2'd3,8'hFF, 2'd0,8'h00, 2'd1,8'h01, 2'd0,8'hFF}, 35'h3FF0101FF, 35'h3FF0100FF};
      tbl[1] = '{{2'd3,8'hFF, 2'd3,8'hFF, 2'd3,8'hFF, 2'd3,8'hFF}, 35'h4030302FF, 35'h4030301FF};
      tbl[2] = '{40'h0,                                              35'h0,         35'h0};
      tbl[3] = '{{2'd0,8'h00, 2'd0,8'h00, 2'd0,8'h01, 2'd0,8'h80}, 35'h180,       35'h080};
      tbl[4] = '{{2'd0,8'h00, 2'd0,8'h00, 2'd0,8'h00, 2'd0,8'hFF}, 35'h0FF,       35'h0FF};
      tbl[5] = '{{2'd0,8'h00, 2'd0,8'h00, 2'd0,8'h00, 2'd1,8'h00}, 35'h100,       35'h000};
      tbl[6] = '{{2'd0,8'h00, 2'd0,8'h00, 2'd0,8'h00, 2'd2,8'hFF}, 35'h2FF,       35'h1FF};
      tbl[7] = '{{2'd0,8'hFF, 2'd0,8'hFF, 2'd0,8'hFF, 2'd3,8'hFF}, 35'h1000002FF, 35'h1000001FF};

      rst = 1'b1; iv = 1'b0; ip = '0; or_ = 1'b0;
      d_iv = 1'b0; d_ip = '0; d_or = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_in_ready",  413'(a_ir), 413'(1));
      chk("rst_out_valid", 413'(a_ov), 413'(0));
      chk("rst_out_uint",  413'(a_ou), 413'(0));
      chk("rst_d_out_uint", d_ou, 413'(0));

      for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

      // Held output: DONE with out_ready low, plus an input pulse that must be ignored.
      ip = tbl[1].poly; iv = 1'b1;
      @(posedge clk); #1;
      iv = 1'b0;
      seen = 1'b0;
      for (int w = 0; w < 12 && !seen; w++) begin
         @(posedge clk); #1;
         if (a_ov && r_ov) seen = 1'b1;
      end
      chk("stall_reach_done", 413'(seen), 413'(1));
      for (int c = 0; c < 10; c++) begin
         if (c == 2) begin iv = 1'b1; ip = {2'd0,8'h00, 2'd0,8'h00, 2'd0,8'h00, 2'd0,8'h01}; end
         if (c == 3) iv = 1'b0;
         @(posedge clk); #1;
         chk("stall_val_a",  413'(a_ou), 413'(tbl[1].ea));
         chk("stall_val_r",  413'(r_ou), 413'(tbl[1].er));
         chk("stall_ready",  413'(a_ir), 413'(0));
         chk("stall_valid",  413'(a_ov), 413'(1));
      end
      iv = 1'b0;
      or_ = 1'b1;
      @(posedge clk); #1;
      or_ = 1'b0;
      chk("stall_release_ready", 413'(a_ir), 413'(1));
      chk("stall_release_valid", 413'(a_ov), 413'(0));
      seen = 1'b0;
      for (int w = 0; w < 6; w++) begin
         @(posedge clk); #1;
         if (a_ov || r_ov || !a_ir) seen = 1'b1;
      end
      chk("stall_pulse_ignored", 413'(seen), 413'(0));

      // Reset in the middle of propagation (cnt == 2).
      ip = tbl[0].poly; iv = 1'b1;
      @(posedge clk); #1;
      iv = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_ready",  413'(a_ir), 413'(1));
      chk("midrst_valid",  413'(a_ov), 413'(0));
      chk("midrst_uint",   413'(a_ou), 413'(0));
      chk("midrst_r_uint", 413'(r_ou), 413'(0));
      seen = 1'b0;
      for (int w = 0; w < 8; w++) begin
         @(posedge clk); #1;
         if (a_ov || r_ov) seen = 1'b1;
      end
      chk("midrst_no_output", 413'(seen), 413'(0));
      run_vec(8, tbl[7]);

      // Random back-to-back words on the default instance with output stalls.
      fork
         begin
            bit acc;
            for (int n = 0; n < 1000; n++) begin
               rp = '0;
               for (int k = 0; k < 14; k++) rp = {rp[403:0], 32'($urandom())};
               case ($urandom_range(0, 7))
                  0: rp = '1;
                  1: rp = '0;
                  default: ;
               endcase
               d_ip = rp; d_iv = 1'b1;
               acc = 1'b0;
               for (int w = 0; w < 200 && !acc; w++) begin
                  @(negedge clk);
                  if (d_ir) acc = 1'b1;
               end
               if (!acc) begin
                  chk("rand_accept_timeout", 413'(0), 413'(1));
                  break;
               end
               exp_q.push_back(ref_val(rp));
               @(posedge clk); #1;
            end
            d_iv = 1'b0;
            gen_done = 1'b1;
         end
         begin
            while (!gen_done) begin
               @(posedge clk); #1;
               d_or = ($urandom_range(0, 3) != 0);
            end
            d_or = 1'b1;
         end
      join
      for (int w = 0; w < 300 && exp_q.size() != 0; w++) @(posedge clk);
      @(posedge clk); #1;
      chk("sb_drain", 413'(exp_q.size()), 413'(0));
      chk("sb_count", 413'(npop), 413'(1000));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
